// File: rtl/uart_pkg.sv
// Shared UART frame constants and state encoding, used by both the receiver and the transmitter.
// Everything that defines the 8N1 frame on the wire lives here.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_TIMER_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START_BIT  = 3'd1,
        ST_DATA_BITS  = 3'd2,
        ST_STOP_BIT   = 3'd3,
        ST_BREAK_WAIT = 3'd4
    } uart_state_t;

    // Clocks per bit; integer division, so the bit period is truncated.
    function automatic int bit_clks(input int sys_clock, input int baudrate);
        return sys_clock / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts clocks while enabled, flags the mid-bit and end-of-bit points.
// Held at zero when not running so every bit measurement starts from a known count.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic half_tick,
    output logic full_tick
);

    localparam int BIT_CLKS = bit_clks(SYS_CLOCK, UART_BAUDRATE);
    localparam logic [UART_TIMER_W-1:0] HALF_LAST = UART_TIMER_W'(BIT_CLKS / 2 - 1);
    localparam logic [UART_TIMER_W-1:0] FULL_LAST = UART_TIMER_W'(BIT_CLKS - 1);

    logic [UART_TIMER_W-1:0] count_reg;
    logic [UART_TIMER_W-1:0] count_next;

    always_comb begin
        count_next = count_reg + UART_TIMER_W'(1);
        if (clear || !run) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign half_tick = (count_reg == HALF_LAST);
    assign full_tick = (count_reg == FULL_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, finds the start edge, samples each bit mid-period
// and reports either a good byte or a framing error with a single-cycle pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxValid,
    output logic       o_RxFrameErr,
    output logic       o_RxBusy
);

    localparam logic [2:0] LAST_INDEX = 3'(UART_DATA_BITS - 1);

    logic rx_meta_reg;
    logic rx_s_reg;
    logic rx_prev_reg;
    logic fall_edge;

    uart_state_t state_reg;
    uart_state_t state_next;
    logic [2:0]  index_reg;
    logic [2:0]  index_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic [7:0]  byte_reg;
    logic [7:0]  byte_next;
    logic        valid_reg;
    logic        valid_next;
    logic        ferr_reg;
    logic        ferr_next;

    logic timer_clear;
    logic timer_run;
    logic half_tick;
    logic full_tick;

    // Synchronizer flops come out of reset at the idle level so a quiet line sees no edge.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= i_RxSerial;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    assign fall_edge = rx_prev_reg & ~rx_s_reg;

    assign timer_run = (state_reg == ST_START_BIT) ||
                       (state_reg == ST_DATA_BITS) ||
                       (state_reg == ST_STOP_BIT);

    uart_baud_timer #(
        .SYS_CLOCK     (SYS_CLOCK),
        .UART_BAUDRATE (UART_BAUDRATE)
    ) u_baud_timer (
        .clk       (i_SysClock),
        .rst_n     (i_ResetN),
        .clear     (timer_clear),
        .run       (timer_run),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        shift_next  = shift_reg;
        byte_next   = byte_reg;
        valid_next  = 1'b0;
        ferr_next   = 1'b0;
        timer_clear = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_next  = ST_START_BIT;
                    timer_clear = 1'b1;
                end
            end
            ST_START_BIT: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (half_tick) begin
                    timer_clear = 1'b1;
                    if (!rx_s_reg) begin
                        state_next = ST_DATA_BITS;
                        index_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA_BITS: begin
                if (full_tick) begin
                    shift_next[index_reg] = rx_s_reg;
                    index_next  = index_reg + 3'd1;
                    timer_clear = 1'b1;
                    if (index_reg == LAST_INDEX) begin
                        state_next = ST_STOP_BIT;
                    end
                end
            end
            ST_STOP_BIT: begin
                if (full_tick) begin
                    timer_clear = 1'b1;
                    if (rx_s_reg) begin
                        byte_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_BREAK_WAIT;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                // Waiting out a held-low line keeps a break to a single error report.
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            shift_reg <= '0;
            byte_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            shift_reg <= shift_next;
            byte_reg  <= byte_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    assign o_RxByte     = byte_reg;
    assign o_RxValid    = valid_reg;
    assign o_RxFrameErr = ferr_reg;
    assign o_RxBusy     = (state_reg != ST_IDLE);

endmodule
